barrel_normalizer: RTL and testbench

Iterative normalizer that undoes the barrel shifter's left-justification. It accepts a WIDTH-bit word and left-shifts it one bit per cycle until the MSB is set. It returns the normalized word plus the signed shift amount, in the shifter's own encoding, that restores the original: `barrel_shifter(out_data, out_shamt) == in_data`. It sits upstream of the shifter in the normalize/denormalize path and uses valid/ready handshakes on both sides.

---
 rtl/barrel_pkg.sv | 24 ++
 rtl/barrel_normalizer_if.sv | 28 ++
 rtl/barrel_normalizer.sv | 108 ++++++++++
 tb/tb_barrel_normalizer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_pkg.sv
// barrel_pkg: shared types and helpers for the normalize/denormalize path.
//   state_e      - normalizer FSM states
//   shamt_width  - minimum shift-amount width for a given data width
//   neg_shamt    - two's-complement negate that maps 0 to all zeros
package barrel_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    function automatic int unsigned shamt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

    function automatic logic [31:0] neg_shamt(input logic [31:0] mag);
        if (mag == '0) begin
            return '0;
        end
        return ~mag + 32'd1;
    endfunction

endpackage

// File: rtl/barrel_normalizer_if.sv
// barrel_normalizer_if: valid/ready input and result channels of the normalizer.
//   in_valid/in_ready/in_data                  - word to normalize
//   out_valid/out_ready/out_data/out_shamt/out_zero - normalized word and
//                                                 restoring shift amount
//   slave  - normalizer side; master - producer/consumer side
interface barrel_normalizer_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SHW   = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [SHW-1:0]   out_shamt;
    logic             out_zero;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_shamt, out_zero
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_shamt, out_zero
    );
endinterface

// File: rtl/barrel_normalizer.sv
// barrel_normalizer: iterative left-normalizer, one bit per cycle.
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - slave modport: accepts in_data, returns out_data with MSB set,
//            out_shamt = -(leading zeros) in the shifter's two's-complement
//            encoding, and out_zero for an all-zero input.
module barrel_normalizer
    import barrel_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SHW   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    barrel_normalizer_if.slave  bus
);

    if (WIDTH < 2) begin : g_bad_width
        $error("barrel_normalizer: WIDTH must be at least 2");
    end
    if (SHW < shamt_width(WIDTH)) begin : g_bad_shw
        $error("barrel_normalizer: SHW too small for WIDTH");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SHW-1:0]   out_shamt_q, out_shamt_d;
    logic             out_zero_q, out_zero_d;

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_shamt_d = out_shamt_q;
        out_zero_d  = out_zero_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    work_d  = bus.in_data;
                    cnt_d   = '0;
                    state_d = (bus.in_data == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (work_q[WIDTH-1]) begin
                    state_d = DONE;
                end else begin
                    work_d = work_q << 1;
                    cnt_d  = cnt_q + SHW'(1);
                end
            end
            DONE: begin
                out_valid_d = 1'b1;
                // Result registers load once, on the cycle out_valid rises,
                // so they hold still under backpressure.
                if (!out_valid_q) begin
                    out_data_d  = work_q;
                    out_shamt_d = SHW'(neg_shamt(32'(cnt_q)));
                    // A nonzero word never shifts to zero, so an empty work
                    // register here can only mean a zero input.
                    out_zero_d  = (work_q == '0);
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_shamt_q <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_shamt_q <= out_shamt_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_shamt = out_shamt_q;
    assign bus.out_zero  = out_zero_q;

endmodule

// File: tb/tb_barrel_normalizer.sv
// tb_barrel_normalizer: directed self-checking bench for barrel_normalizer
// (WIDTH=4, SHW=4) with a behavioural leading-zero model and a shifter model
// for round-trip checks.
module tb_barrel_normalizer;

    localparam int unsigned W = 4;
    localparam int unsigned S = 4;

    typedef struct {
        logic [W-1:0] d;
        logic [S-1:0] s;
        logic         z;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    barrel_normalizer_if #(.WIDTH(W), .SHW(S)) bus ();

    barrel_normalizer #(.WIDTH(W), .SHW(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: count leading zeros arithmetically; shift amount is -k.
    function automatic void model(input logic [W-1:0] x, output exp_t e, output int lat);
        int k;
        int v;
        v = int'(x);
        k = 0;
        if (v == 0) begin
            e.d = '0; e.s = '0; e.z = 1'b1; lat = 1;
            return;
        end
        while (v < (1 << (W - 1))) begin
            v = v * 2;
            k++;
        end
        e.d = W'(v);
        e.s = S'(-k);
        e.z = 1'b0;
        lat = k + 2;
    endfunction

    // Barrel shifter semantics: non-negative amount shifts left, negative right.
    function automatic logic [W-1:0] shifter(input logic [W-1:0] d, input logic [S-1:0] s);
        int amt;
        amt = int'($signed(s));
        if (amt >= 0) return d << amt;
        return d >> (-amt);
    endfunction

    // Compare process: every valid output cycle is checked against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid: got 1 expected 0");
                end else begin
                    check("cmp_out_data", 32'(bus.out_data), 32'(exp_q[0].d));
                    check("cmp_out_shamt", 32'(bus.out_shamt), 32'(exp_q[0].s));
                    check("cmp_out_zero", 32'(bus.out_zero), 32'(exp_q[0].z));
                    check("cmp_in_ready_low", 32'(bus.in_ready), 32'd0);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Called #1 after a posedge. Returns captured outputs and measured latency.
    task automatic send(input logic [W-1:0] x, input int hold,
                        output logic [W-1:0] got_d, output logic [S-1:0] got_s,
                        output logic got_z, output int lat);
        exp_t e;
        int   mlat;
        int   n;
        model(x, e, mlat);
        got_d = '0; got_s = '0; got_z = 1'b0; lat = 0;
        bus.out_ready = (hold == 0);
        bus.in_valid  = 1'b1;
        bus.in_data   = x;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = W'($urandom);
        check("in_ready_after_accept", 32'(bus.in_ready), 32'd0);
        do begin
            @(posedge clk); #1; lat++;
        end while (!bus.out_valid && lat < 50);
        check("latency", 32'(lat), 32'(mlat));
        got_d = bus.out_data;
        got_s = bus.out_shamt;
        got_z = bus.out_zero;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("hold_out_data", 32'(bus.out_data), 32'(got_d));
            check("hold_out_shamt", 32'(bus.out_shamt), 32'(got_s));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
        check("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t         e;
        int           ml;
        int           lat;
        logic [W-1:0] gd;
        logic [S-1:0] gs;
        logic         gz;
        logic [W-1:0] x;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Pin the model with hand-computed values.
        model(4'b0001, e, ml);
        check("model_0001_d", 32'(e.d), 32'h8);
        check("model_0001_s", 32'(e.s), 32'hd);
        check("model_0001_lat", 32'(ml), 32'd5);
        model(4'b0000, e, ml);
        check("model_zero_z", 32'(e.z), 32'd1);
        check("model_zero_lat", 32'(ml), 32'd1);
        model(4'b0011, e, ml);
        check("model_0011_s", 32'(e.s), 32'he);
        check("shifter_model", 32'(shifter(4'b1000, 4'b1101)), 32'h1);

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_shamt", 32'(bus.out_shamt), 32'd0);
        check("rst_out_zero", 32'(bus.out_zero), 32'd0);
        rst_n = 1'b1;
        #1;
        check("in_ready_before_edge", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        check("in_ready_first_edge", 32'(bus.in_ready), 32'd1);

        send(4'b0001, 0, gd, gs, gz, lat);
        check("t1_data", 32'(gd), 32'h8);
        check("t1_shamt", 32'(gs), 32'hd);
        check("t1_zero", 32'(gz), 32'd0);
        check("t1_lat", 32'(lat), 32'd5);

        send(4'b1010, 0, gd, gs, gz, lat);
        check("t2_data", 32'(gd), 32'ha);
        check("t2_shamt", 32'(gs), 32'h0);
        check("t2_lat", 32'(lat), 32'd2);

        send(4'b0000, 0, gd, gs, gz, lat);
        check("t3_data", 32'(gd), 32'h0);
        check("t3_shamt", 32'(gs), 32'h0);
        check("t3_zero", 32'(gz), 32'd1);
        check("t3_lat", 32'(lat), 32'd1);

        send(4'b0011, 6, gd, gs, gz, lat);
        check("t4_data", 32'(gd), 32'hc);
        check("t4_shamt", 32'(gs), 32'he);

        // Reset while shifting 0001: the word must vanish without a result.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'b0001;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        check("midrst_out_data", 32'(bus.out_data), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(4'b0100, 0, gd, gs, gz, lat);
        check("t5_data", 32'(gd), 32'h8);
        check("t5_shamt", 32'(gs), 32'hf);
        check("t5_lat", 32'(lat), 32'd3);

        // Round trip through the shifter for every input.
        for (int i = 0; i < 16; i++) begin
            x = W'(i);
            send(x, 0, gd, gs, gz, lat);
            check("roundtrip", 32'(shifter(gd, gs)), 32'(x));
        end

        repeat (3) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
